board_reset_ctrl: RTL and testbench

Parametrised board-level reset sequencer and push-button conditioner, running on the free-running board reference clock ahead of the PLL. It replaces the ad-hoc two-flop reset chains in each board top. It debounces N active-low buttons, sequences PLL reset, waits for lock with timeout, then holds the SoC reset for a programmable time. An optional watchdog re-issues the SoC reset when software stops kicking it; `soc_reset` is re-synchronised into each PLL output domain by the board top.

---
 rtl/board_pkg.sv | 25 ++
 rtl/button_debounce.sv | 55 +++++
 rtl/board_reset_ctrl.sv | 138 +++++++++++++
 tb/tb_board_reset_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared definitions for the board reset sequencer: FSM state encoding and
// default parameter values.
package board_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int DEF_BUTTONS           = 2;
    localparam int DEF_DEBOUNCE_BITS     = 16;
    localparam int DEF_PLL_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT_BITS = 20;
    localparam int DEF_HOLD_CYCLES       = 256;
    localparam int DEF_WDT_BITS          = 24;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button channel: two-flop synchroniser on the inverted active-low
// input, stability counter, debounced level and one-cycle press event.
module button_debounce
    import board_pkg::*;
#(
    parameter int DEBOUNCE_BITS = DEF_DEBOUNCE_BITS
) (
    input  logic clk,
    input  logic reset,
    input  logic button_n_i,
    output logic pressed_o,
    output logic event_o
);

    logic                     sync1_q, sync2_q;
    logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
    logic                     pressed_q, pressed_d;
    logic                     event_q, event_d;

    always_comb begin
        cnt_d     = cnt_q;
        pressed_d = pressed_q;
        event_d   = 1'b0;
        if (sync2_q == pressed_q) begin
            cnt_d = '0;
        end else if (&cnt_q) begin
            // Input has disagreed with the level for the full window: accept it
            pressed_d = sync2_q;
            cnt_d     = '0;
            event_d   = sync2_q;
        end else begin
            cnt_d = cnt_q + {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            event_q   <= 1'b0;
        end else begin
            sync1_q   <= ~button_n_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            event_q   <= event_d;
        end
    end

    assign pressed_o = pressed_q;
    assign event_o   = event_q;

endmodule

// File: rtl/board_reset_ctrl.sv
// Board reset sequencer: button debounce, PLL reset / lock wait, SoC reset hold.
// Optional watchdog enabled by defining BOARD_RESET_WDT_EN.
module board_reset_ctrl
    import board_pkg::*;
#(
    parameter int BUTTONS           = DEF_BUTTONS,
    parameter int DEBOUNCE_BITS     = DEF_DEBOUNCE_BITS,
    parameter int PLL_RST_CYCLES    = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT_BITS = DEF_LOCK_TIMEOUT_BITS,
    parameter int HOLD_CYCLES       = DEF_HOLD_CYCLES,
    parameter int WDT_BITS          = DEF_WDT_BITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BUTTONS-1:0] button_n,
    input  logic               pll_locked,
    input  logic               wdt_kick,
    output logic               pll_reset,
    output logic               soc_reset,
    output logic [BUTTONS-1:0] button_pressed,
    output logic [BUTTONS-1:0] button_event,
    output logic [1:0]         seq_state,
    output logic               wdt_fired
);

    localparam int CNT_W = max3(LOCK_TIMEOUT_BITS, $clog2(PLL_RST_CYCLES + 1),
                                $clog2(HOLD_CYCLES + 1));
    localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = {CNT_W{1'b1}} >> (CNT_W - LOCK_TIMEOUT_BITS);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_s1_q, lock_s_q;
    logic             pll_reset_q, soc_reset_q;
    logic             wdt_expire;

    genvar gi;
    generate
        for (gi = 0; gi < BUTTONS; gi++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_BITS(DEBOUNCE_BITS)
            ) u_debounce (
                .clk       (clk),
                .reset     (reset),
                .button_n_i(button_n[gi]),
                .pressed_o (button_pressed[gi]),
                .event_o   (button_event[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        case (state_q)
            PLL_RST: begin
                if (cnt_q == PLL_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s_q)                state_d = HOLD;
                else if (cnt_q == TO_LAST)   state_d = PLL_RST;
            end
            HOLD: begin
                if (!lock_s_q)               state_d = PLL_RST;
                else if (cnt_q == HOLD_LAST) state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q;
                if (!lock_s_q)               state_d = PLL_RST;
                else if (wdt_expire)         state_d = HOLD;
            end
            default: state_d = PLL_RST;
        endcase
        // The reset button overrides everything and restarts the PLL count
        if (button_event[0]) state_d = PLL_RST;
        if (state_d != state_q || button_event[0]) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            lock_s1_q   <= 1'b0;
            lock_s_q    <= 1'b0;
            pll_reset_q <= 1'b1;
            soc_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lock_s1_q   <= pll_locked;
            lock_s_q    <= lock_s1_q;
            pll_reset_q <= (state_d == PLL_RST);
            soc_reset_q <= (state_d != RUN);
        end
    end

`ifdef BOARD_RESET_WDT_EN
    // Expiry is taken on the cycle whose increment would reach all-ones
    localparam logic [WDT_BITS-1:0] WDT_LAST = {{(WDT_BITS-1){1'b1}}, 1'b0};

    logic [WDT_BITS-1:0] wdt_cnt_q, wdt_cnt_d;
    logic                wdt_fired_q, wdt_fired_d;

    assign wdt_expire = (state_q == RUN) && !wdt_kick && (wdt_cnt_q == WDT_LAST);

    always_comb begin
        wdt_cnt_d   = '0;
        wdt_fired_d = wdt_fired_q;
        if (state_q == RUN && !wdt_kick)
            wdt_cnt_d = wdt_cnt_q + {{(WDT_BITS-1){1'b0}}, 1'b1};
        if (button_event[0])  wdt_fired_d = 1'b0;
        else if (wdt_expire)  wdt_fired_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wdt_cnt_q   <= '0;
            wdt_fired_q <= 1'b0;
        end else begin
            wdt_cnt_q   <= wdt_cnt_d;
            wdt_fired_q <= wdt_fired_d;
        end
    end

    assign wdt_fired = wdt_fired_q;
`else
    logic unused_wdt;
    assign unused_wdt = wdt_kick & (WDT_BITS > 0);
    assign wdt_expire = 1'b0;
    assign wdt_fired  = 1'b0;
`endif

    assign pll_reset = pll_reset_q;
    assign soc_reset = soc_reset_q;
    assign seq_state = state_q;

endmodule

// File: tb/tb_board_reset_ctrl.sv
// Directed bench for board_reset_ctrl with short counters; watchdog steps
// are built only when BOARD_RESET_WDT_EN is defined.
module tb_board_reset_ctrl;

    localparam int BUTTONS = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [BUTTONS-1:0] button_n;
    logic               pll_locked;
    logic               wdt_kick;
    logic               pll_reset;
    logic               soc_reset;
    logic [BUTTONS-1:0] button_pressed;
    logic [BUTTONS-1:0] button_event;
    logic [1:0]         seq_state;
    logic               wdt_fired;

    int vectors     = 0;
    int miscompares = 0;

    board_reset_ctrl #(
        .BUTTONS          (BUTTONS),
        .DEBOUNCE_BITS    (4),
        .PLL_RST_CYCLES   (16),
        .LOCK_TIMEOUT_BITS(6),
        .HOLD_CYCLES      (256),
        .WDT_BITS         (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .button_n      (button_n),
        .pll_locked    (pll_locked),
        .wdt_kick      (wdt_kick),
        .pll_reset     (pll_reset),
        .soc_reset     (soc_reset),
        .button_pressed(button_pressed),
        .button_event  (button_event),
        .seq_state     (seq_state),
        .wdt_fired     (wdt_fired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (seq_state != 2'd3 && n < 1000) begin
            tick();
            n++;
        end
        check(tag, seq_state, 2'd3);
    endtask

    initial begin
        int n, fall_t, bad, ev, ev_t, soc_low;
        int falls[2], rises[2];
        int nf, nr;
        logic prev;

        reset = 1'b1; button_n = 2'b11; pll_locked = 1'b0; wdt_kick = 1'b0;
        repeat (5) tick();
        check("rst_pll_reset", pll_reset, 1);
        check("rst_soc_reset", soc_reset, 1);
        check("rst_state", seq_state, 0);
        check("rst_pressed", button_pressed, 0);
        check("rst_event", button_event, 0);
        check("rst_wdt_fired", wdt_fired, 0);

        // Power-on: pll_reset pulse, then lock at cycle 40
        reset = 1'b0;
        n = 0;
        do begin tick(); n++; end while (pll_reset && n < 100);
        check("por_pll_pulse_len", n, 16);
        check("por_wait_lock", seq_state, 1);
        fall_t = 0; bad = 0;
        for (int t = 17; t <= 400; t++) begin
            tick();
            if (t == 42) check("lock_not_yet_hold", seq_state, 1);
            if (t == 43) check("lock_hold_entry", seq_state, 2);
            if (pll_reset) bad++;
            if (!soc_reset) begin fall_t = t; break; end
            if (t == 40) pll_locked = 1'b1;
        end
        check("soc_fall_cycle", fall_t, 299);
        check("por_run", seq_state, 3);
        check("por_pll_stayed_low", bad, 0);

        // Lock loss in RUN
        pll_locked = 1'b0; tick();
        pll_locked = 1'b1; tick();
        check("runloss_still_run", seq_state, 3);
        tick();
        check("runloss_pll_rst", seq_state, 0);
        check("runloss_pll_reset", pll_reset, 1);
        check("runloss_soc_reset", soc_reset, 1);
        repeat (15) tick();
        check("runloss_pll_high_16", pll_reset, 1);
        tick();
        check("runloss_pll_low_17", pll_reset, 0);
        tick();
        check("relock_hold", seq_state, 2);

        // Lock loss in HOLD; lock stays low for the timeout check
        repeat (5) tick();
        pll_locked = 1'b0; tick(); tick();
        check("holdloss_still_hold", seq_state, 2);
        tick();
        check("holdloss_pll_rst", seq_state, 0);

        // Lock timeout: pll_reset re-pulses every 16 + 64 cycles
        prev = pll_reset; nf = 0; nr = 0; soc_low = 0;
        falls[0] = 0; falls[1] = 0; rises[0] = 0; rises[1] = 0;
        for (int r = 1; r <= 170; r++) begin
            tick();
            if (prev && !pll_reset && nf < 2) begin falls[nf] = r; nf++; end
            if (!prev && pll_reset && nr < 2) begin rises[nr] = r; nr++; end
            if (!soc_reset) soc_low++;
            prev = pll_reset;
        end
        check("timeout_fall1", falls[0], 16);
        check("timeout_rise1", rises[0], 80);
        check("timeout_fall2", falls[1], 96);
        check("timeout_rise2", rises[1], 160);
        check("timeout_soc_held", soc_low, 0);

        pll_locked = 1'b1;
        wait_run("recover_run");

        // 10-cycle glitch on button 1
        button_n[1] = 1'b0; ev = 0;
        for (int r = 1; r <= 50; r++) begin
            tick();
            if (button_event[1]) ev++;
            if (r == 10) button_n[1] = 1'b1;
        end
        check("glitch_events", ev, 0);
        check("glitch_pressed", button_pressed[1], 0);

        // 30-cycle press on button 1
        button_n[1] = 1'b0; ev = 0; ev_t = 0;
        for (int r = 1; r <= 60; r++) begin
            tick();
            if (button_event[1]) begin
                ev++;
                if (ev_t == 0) ev_t = r;
            end
            if (r == 18) check("press_level", button_pressed[1], 1);
            if (r == 30) button_n[1] = 1'b1;
        end
        check("press_event_count", ev, 1);
        check("press_event_cycle", ev_t, 18);
        check("press_released", button_pressed[1], 0);
        check("press_state_run", seq_state, 3);

        // Button 0 in RUN
        button_n[0] = 1'b0;
        repeat (17) tick();
        check("btn0_no_event_17", button_event[0], 0);
        tick();
        check("btn0_event_18", button_event[0], 1);
        check("btn0_still_run", seq_state, 3);
        tick();
        check("btn0_pll_rst", seq_state, 0);
        check("btn0_pll_reset", pll_reset, 1);
        check("btn0_event_one_cycle", button_event[0], 0);
        button_n[0] = 1'b1;
        n = 1;
        do begin tick(); n++; end while (pll_reset && n < 100);
        check("btn0_pll_pulse_len", n, 17);
        check("btn0_wdt_clear", wdt_fired, 0);
        wait_run("btn0_run");

`ifdef BOARD_RESET_WDT_EN
        // No kicks: HOLD 255 cycles after RUN, PLL untouched
        n = 0; bad = 0;
        for (int r = 1; r <= 300; r++) begin
            tick();
            if (pll_reset) bad++;
            if (seq_state == 2'd2) begin n = r; break; end
        end
        check("wdt_hold_cycle", n, 255);
        check("wdt_fired_set", wdt_fired, 1);
        check("wdt_pll_low", bad, 0);
        check("wdt_soc_reset", soc_reset, 1);
        wait_run("wdt_rerun");
        bad = 0;
        for (int r = 1; r <= 1000; r++) begin
            tick();
            wdt_kick = (r % 200 == 0);
            if (seq_state != 2'd3) bad++;
        end
        wdt_kick = 1'b0;
        check("wdt_kicked_no_fire", bad, 0);
        check("wdt_fired_sticky", wdt_fired, 1);
`else
        bad = 0;
        for (int r = 1; r <= 300; r++) begin
            tick();
            wdt_kick = (r % 97 == 0);
            if (seq_state != 2'd3 || wdt_fired) bad++;
        end
        wdt_kick = 1'b0;
        check("nowdt_stays_run", bad, 0);
`endif

        // Reset mid-sequence
        reset = 1'b1;
        tick();
        check("midrst_pll_reset", pll_reset, 1);
        check("midrst_soc_reset", soc_reset, 1);
        check("midrst_state", seq_state, 0);
        check("midrst_pressed", button_pressed, 0);
        check("midrst_wdt_fired", wdt_fired, 0);
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
